seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request a new operation; sampled only in IDLE.
REQ-005 Q  input  4  multiplier operand (quotient, unsigned).
REQ-006 B  input  4  multiplicand operand (divisor, unsigned).
REQ-007 R  input  4  addend operand (remainder, unsigned).
REQ-008 P  output  8  result P = Q*B + R, unsigned; registered.
REQ-009 BUSY  output  1  high while an operation is in progress.
REQ-010 DONE  output  1  one-cycle pulse marking P updated with a new result.

Function
REQ-011 The block SHALL reconstruct a dividend from a quotient, divisor and remainder by computing P = Q*B + R with no truncation (maximum value 15*15+15 = 240 fits in 8 bits).
REQ-012 The block SHALL implement the FSM states IDLE and RUN plus a 2-bit step counter.
REQ-013 IDLE with START=1 at an edge SHALL do the following at that edge:
- latch Q into the multiplier shift register and B zero-extended to 8 bits into the multiplicand register;
- load R zero-extended into the 8-bit accumulator;
- clear the step counter, enter RUN and set BUSY=1.
REQ-014 Each edge in RUN SHALL perform one shift-add step:
- if the multiplier LSB is 1, add the multiplicand to the accumulator (8-bit add);
- then shift the multiplier right by 1 and the multiplicand left by 1;
- then increment the step counter.
REQ-015 On the 4th RUN edge (step counter = 3), the block SHALL do the following:
- write the final accumulator value, including that step's add, into P;
- set DONE=1, set BUSY=0 and return to IDLE.
REQ-016 Latency SHALL be exactly 4 clock edges from the START-accepting edge to the edge that asserts DONE; BUSY SHALL be high for exactly 4 cycles.
REQ-017 DONE SHALL be high for exactly one cycle and SHALL deassert on the following edge unless that edge completes another operation (not possible given REQ-016).
REQ-018 P SHALL hold the previous result throughout RUN and SHALL change only on a completing edge or on reset.
REQ-019 START, Q, B and R SHALL be ignored while in RUN; operands are used only at the accepting edge, so later input changes do not affect the result.
REQ-020 START=1 in the cycle where DONE=1 SHALL be accepted as a new operation, since the FSM is then in IDLE; back-to-back throughput is one result per 5 cycles.
REQ-021 START held continuously high SHALL start a new operation on every IDLE edge, with no edge detection.
REQ-022 Operands of 0 (Q=0 or B=0) SHALL still take the full 4 steps and yield P=R.
REQ-023 Accumulator overflow SHALL be impossible by REQ-011; no carry-out port is provided.

Reset
REQ-024 RST=1 SHALL immediately force the following values, independent of CLK:
- IDLE, step counter=0, accumulator=0, multiplier and multiplicand registers=0;
- P=0, BUSY=0, DONE=0.
REQ-025 RST asserted mid-RUN SHALL abort the operation; no DONE pulse SHALL follow, and P SHALL read 0.
REQ-026 After RST deasserts, the first rising edge with START=1 SHALL be accepted normally.

Verification
REQ-027 Q=5, B=3, R=2, one-cycle START -> BUSY high for 4 cycles; DONE pulses on the 4th edge after the accepting edge; P=17 (0x11).
REQ-028 Q=15, B=15, R=15 -> P=240 (0xF0); then Q=0, B=9, R=7 -> P=7; then Q=6, B=0, R=0 -> P=0; each takes 4 steps.
REQ-029 START held high; operands changed to Q=1, B=1, R=1 during RUN of Q=3, B=4, R=1 -> first DONE gives P=13; a new operation is accepted in the DONE cycle; second DONE, 5 edges later, gives P=2.
REQ-030 RST pulsed during the 2nd RUN cycle of Q=7, B=7, R=0 -> P=0, BUSY=0 immediately, and no DONE; a subsequent START with the same operands gives P=49.
REQ-031 Exhaustive round-trip: for all A in 0..15 and B in 1..15, Q=A/B and R=A%B from the team's combinational divider -> P == A for all 240 cases, with DONE seen once per case.

Source files
------------

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/result bundle for the shift-add multiplier
//
// Signals:
//   start - request a new operation (sampled only while the multiplier is idle)
//   q     - 4-bit multiplier operand (quotient, unsigned)
//   b     - 4-bit multiplicand operand (divisor, unsigned)
//   r     - 4-bit addend operand (remainder, unsigned)
//   p     - 8-bit registered result Q*B+R
//   busy  - high while an operation is in progress
//   done  - one-cycle pulse when p carries a new result
// Modports:
//   master - requester side: drives start/q/b/r, observes p/busy/done
//   slave  - multiplier side: consumes start/q/b/r, drives p/busy/done
interface seq_multiplier_if;
  logic       start;
  logic [3:0] q;
  logic [3:0] b;
  logic [3:0] r;
  logic [7:0] p;
  logic       busy;
  logic       done;

  modport master (output start, q, b, r, input p, busy, done);
  modport slave  (input start, q, b, r, output p, busy, done);
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 4-step shift-add multiplier computing P = Q*B + R
//
// Ports:
//   clk_i - system clock, all state updates on the rising edge
//   rst_i - asynchronous active-high reset
//   bus   - seq_multiplier_if.slave: start/q/b/r in, p/busy/done out
//
// An accepted request loads the accumulator with R, so the four shift-add
// steps finish with Q*B + R directly and no final add is needed.
module seq_multiplier (
  input  logic                  clk_i,
  input  logic                  rst_i,
  seq_multiplier_if.slave       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q,  step_d;
  logic [7:0]  acc_q,   acc_d;
  logic [3:0]  mplr_q,  mplr_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  p_q,     p_d;
  logic        done_q,  done_d;
  logic [7:0]  acc_sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      acc_q   <= 8'd0;
      mplr_q  <= 4'd0;
      mcand_q <= 8'd0;
      p_q     <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    done_d  = 1'b0;
    // Partial product for this step; the largest possible total is 240,
    // so the 8-bit add never carries out.
    acc_sum = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mplr_d  = bus.q;
          mcand_d = {4'd0, bus.b};
          acc_d   = {4'd0, bus.r};
          step_d  = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_sum;
        mplr_d  = mplr_q >> 1;
        mcand_d = mcand_q << 1;
        step_d  = step_q + 2'd1;
        if (step_q == 2'd3) begin
          // Publish the sum including this last step's add.
          p_d     = acc_sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy tracks RUN exactly: raised by the accepting edge, dropped by the
  // completing edge, which gives four busy cycles per operation.
  assign bus.p    = p_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] prev_p;

  seq_multiplier_if bus ();

  seq_multiplier dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one single-cycle START at a falling edge and follow the operation.
  // Operands are scrambled right after the accepting edge to show they are
  // captured only at that edge.
  task automatic run_op(input string tag, input logic [3:0] q, input logic [3:0] b,
                        input logic [3:0] r, input logic [7:0] exp_p);
    int lat    = 0;
    int busy_n = 0;
    int done_n = 0;
    bus.start = 1'b1;
    bus.q = q;
    bus.b = b;
    bus.r = r;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.q = 4'($urandom);
        bus.b = 4'($urandom);
        bus.r = 4'($urandom);
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        done_n++;
        if (lat == 0) lat = i;
      end
      if (lat == 0) chk({tag, "_p_hold"}, 32'(bus.p), 32'(prev_p));
    end
    // Sample index 5 follows the 4th edge after the accepting edge.
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_cycles"}, busy_n, 4);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_p"}, 32'(bus.p), 32'(exp_p));
    prev_p = exp_p;
  endtask

  initial begin
    int first_done;
    int second_done;
    int done_n;
    logic [3:0] rq, rb, rr;
    int e;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.q = 4'd0;
    bus.b = 4'd0;
    bus.r = 4'd0;
    prev_p = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_p", 32'(bus.p), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic and boundary operands.
    run_op("q5b3r2", 4'd5, 4'd3, 4'd2, 8'd17);
    run_op("max", 4'd15, 4'd15, 4'd15, 8'd240);
    run_op("q0", 4'd0, 4'd9, 4'd7, 8'd7);
    run_op("b0", 4'd6, 4'd0, 4'd0, 8'd0);

    // START held high: operands changed during RUN, re-accept in DONE cycle.
    first_done  = 0;
    second_done = 0;
    bus.start = 1'b1;
    bus.q = 4'd3;
    bus.b = 4'd4;
    bus.r = 4'd1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.q = 4'd1;
        bus.b = 4'd1;
        bus.r = 4'd1;
      end
      if (i == 6) begin
        chk("held_reaccept_busy", 32'(bus.busy), 1);
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        if (first_done == 0) begin
          first_done = i;
          chk("held_first_p", 32'(bus.p), 13);
        end else if (second_done == 0) begin
          second_done = i;
          chk("held_second_p", 32'(bus.p), 2);
        end
      end
    end
    chk("held_first_latency", first_done, 5);
    chk("held_second_latency", second_done, 10);
    prev_p = 8'd2;

    // Reset during the second RUN cycle aborts without a DONE.
    bus.start = 1'b1;
    bus.q = 4'd7;
    bus.b = 4'd7;
    bus.r = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_p", 32'(bus.p), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    prev_p = 8'd0;
    done_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_p_after", 32'(bus.p), 0);
    run_op("after_abort", 4'd7, 4'd7, 4'd0, 8'd49);

    // Random operands against Q*B+R.
    for (int k = 0; k < 40; k++) begin
      rq = 4'($urandom);
      rb = 4'($urandom);
      rr = 4'($urandom);
      e = int'(rq) * int'(rb) + int'(rr);
      run_op("random", rq, rb, rr, 8'(e));
    end

    // Round trip of every dividend/divisor split: Q*B + R must rebuild A.
    for (int a = 0; a < 16; a++) begin
      for (int d = 1; d < 16; d++) begin
        run_op("roundtrip", 4'(a / d), 4'(d), 4'(a % d), 8'(a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
